// File: rtl/pipe_ctrl_pkg.sv
// Shared types and widths for the pipeline hazard controller.
package pipe_ctrl_pkg;
    localparam int REG_ADDR_W  = 5;
    localparam int STALL_CNT_W = 16;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_HALTED   = 3'd3,
        ST_ERROR    = 3'd4
    } state_e;
endpackage

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Load-use hazard compare between the load in EX and the sources of the instruction in ID.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] id_rs_i,
    input  logic [REG_ADDR_W-1:0] id_rt_i,
    input  logic                  id_uses_rt_i,
    input  logic                  ex_mem_read_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    output logic                  load_use_o
);
    logic rd_nonzero;
    logic rs_hit;
    logic rt_hit;

    // r0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign rd_nonzero = (ex_rd_i != '0);
    assign rs_hit     = (ex_rd_i == id_rs_i);
    assign rt_hit     = id_uses_rt_i & (ex_rd_i == id_rt_i);
    assign load_use_o = ex_mem_read_i & rd_nonzero & (rs_hit | rt_hit);
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: hazard priority, memory-wait
// timeout, halt drain, and a saturating stall-cycle counter.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT  = 15,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [REG_ADDR_W-1:0]  id_rs,
    input  logic [REG_ADDR_W-1:0]  id_rt,
    input  logic                   id_uses_rt,
    input  logic                   ex_mem_read,
    input  logic [REG_ADDR_W-1:0]  ex_rd,
    input  logic                   mem_branch_taken,
    input  logic                   mem_req,
    input  logic                   mem_ready,
    input  logic                   halt_req,
    output logic                   pc_en,
    output logic                   pc_sel_branch,
    output logic                   if_id_en,
    output logic                   if_id_flush,
    output logic                   id_ex_en,
    output logic                   id_ex_flush,
    output logic                   ex_mem_en,
    output logic                   ex_mem_flush,
    output logic                   mem_wb_bubble,
    output logic                   halted,
    output logic                   mem_err,
    output logic [STALL_CNT_W-1:0] stall_count,
    output logic [2:0]             dbg_state
);
    localparam logic [7:0] WAIT_LAST  = 8'(MEM_TIMEOUT - 1);
    localparam logic [2:0] DRAIN_LAST = 3'(DRAIN_CYCLES - 1);

    state_e                 state_q, state_d;
    logic [7:0]             wait_cnt_q, wait_cnt_d;
    logic [2:0]             drain_cnt_q, drain_cnt_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic                   mem_err_q;
    logic                   load_use;
    logic                   mem_stall;
    logic                   timeout;
    logic                   active;

    load_use_detect u_load_use (
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .ex_mem_read_i (ex_mem_read),
        .ex_rd_i       (ex_rd),
        .load_use_o    (load_use)
    );

    assign mem_stall = mem_req & ~mem_ready;
    // Fires on the cycle that would complete the MEM_TIMEOUT-th consecutive stall.
    assign timeout   = mem_stall & (wait_cnt_q == WAIT_LAST);
    assign active    = (state_q != ST_HALTED) && (state_q != ST_ERROR);

    always_comb begin
        pc_en         = 1'b1;
        pc_sel_branch = 1'b0;
        if_id_en      = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_en      = 1'b1;
        id_ex_flush   = 1'b0;
        ex_mem_en     = 1'b1;
        ex_mem_flush  = 1'b0;
        mem_wb_bubble = 1'b0;
        state_d       = state_q;
        wait_cnt_d    = '0;
        drain_cnt_d   = '0;
        case (state_q)
            ST_RUN, ST_MEM_WAIT, ST_DRAIN: begin
                if (mem_stall) begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_en     = 1'b0;
                    mem_wb_bubble = 1'b1;
                    wait_cnt_d    = wait_cnt_q + 8'd1;
                end else if (mem_branch_taken) begin
                    pc_sel_branch = 1'b1;
                    if_id_flush   = 1'b1;
                    id_ex_flush   = 1'b1;
                    ex_mem_flush  = 1'b1;
                end else if (load_use) begin
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
                // While draining, only a resolved branch may still move the PC.
                if (state_q == ST_DRAIN && !(!mem_stall && mem_branch_taken)) begin
                    pc_en       = 1'b0;
                    if_id_flush = 1'b1;
                end
                if (timeout) begin
                    state_d = ST_ERROR;
                end else if (state_q == ST_DRAIN) begin
                    drain_cnt_d = drain_cnt_q;
                    if (!halt_req) begin
                        state_d = mem_stall ? ST_MEM_WAIT : ST_RUN;
                    end else if (!mem_stall) begin
                        if (drain_cnt_q == DRAIN_LAST) state_d = ST_HALTED;
                        else drain_cnt_d = drain_cnt_q + 3'd1;
                    end
                end else if (mem_stall) begin
                    state_d = ST_MEM_WAIT;
                end else if (halt_req) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                if (!halt_req) state_d = ST_RUN;
            end
            default: begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
            end
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (active && !pc_en && stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= '0;
            drain_cnt_q <= '0;
            stall_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            mem_err_q   <= mem_err_q | (state_d == ST_ERROR);
        end
    end

    assign halted      = (state_q == ST_HALTED);
    assign mem_err     = mem_err_q;
    assign stall_count = stall_cnt_q;
    assign dbg_state   = state_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed stimulus scored against a behavioural model of the
// hazard controller; a monitor pops one expected output set per cycle.
module tb_pipeline_hazard_ctrl;
    localparam int MEM_TIMEOUT  = 15;
    localparam int DRAIN_CYCLES = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  id_rs = '0, id_rt = '0, ex_rd = '0;
    logic        id_uses_rt = 1'b0, ex_mem_read = 1'b0, mem_branch_taken = 1'b0;
    logic        mem_req = 1'b0, mem_ready = 1'b0, halt_req = 1'b0;
    logic        pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en, id_ex_flush;
    logic        ex_mem_en, ex_mem_flush, mem_wb_bubble, halted, mem_err;
    logic [15:0] stall_count;
    logic [2:0]  dbg_state;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .DRAIN_CYCLES(DRAIN_CYCLES)) dut (
        .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .mem_branch_taken(mem_branch_taken),
        .mem_req(mem_req), .mem_ready(mem_ready), .halt_req(halt_req),
        .pc_en(pc_en), .pc_sel_branch(pc_sel_branch), .if_id_en(if_id_en),
        .if_id_flush(if_id_flush), .id_ex_en(id_ex_en), .id_ex_flush(id_ex_flush),
        .ex_mem_en(ex_mem_en), .ex_mem_flush(ex_mem_flush), .mem_wb_bubble(mem_wb_bubble),
        .halted(halted), .mem_err(mem_err), .stall_count(stall_count), .dbg_state(dbg_state)
    );

    // Expected entry: {11 control bits, 16-bit stall count}
    logic [26:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    // Behavioural model: error/halted/draining flags plus plain integer counters.
    bit m_err, m_halted, m_drain;
    int m_consec, m_drained, m_stalls;

    task automatic model_reset();
        m_err = 0; m_halted = 0; m_drain = 0;
        m_consec = 0; m_drained = 0; m_stalls = 0;
    endtask

    task automatic drive_cycle(input bit do_reset, input logic [4:0] rs, input logic [4:0] rt,
                               input logic [4:0] rd, input bit urt, input bit mrd, input bit br,
                               input bit mq, input bit mrdy, input bit hr);
        bit lu, ms, e_pc, e_sel, e_ifen, e_iffl, e_idexen, e_idexfl, e_exen, e_exfl, e_bub;
        @(posedge clk);
        #1;
        id_rs = rs; id_rt = rt; ex_rd = rd; id_uses_rt = urt; ex_mem_read = mrd;
        mem_branch_taken = br; mem_req = mq; mem_ready = mrdy; halt_req = hr;
        rst_n = !do_reset;
        if (do_reset) model_reset();
        lu = mrd && rd != 0 && (rd == rs || (urt && rd == rt));
        ms = mq && !mrdy;
        e_pc = 1; e_sel = 0; e_ifen = 1; e_iffl = 0; e_idexen = 1; e_idexfl = 0;
        e_exen = 1; e_exfl = 0; e_bub = 0;
        if (m_err || m_halted) begin
            e_pc = 0; e_ifen = 0; e_idexen = 0; e_exen = 0;
        end else begin
            if (ms) begin
                e_pc = 0; e_ifen = 0; e_idexen = 0; e_exen = 0; e_bub = 1;
            end else if (br) begin
                e_sel = 1; e_iffl = 1; e_idexfl = 1; e_exfl = 1;
            end else if (lu) begin
                e_pc = 0; e_ifen = 0; e_idexfl = 1;
            end
            if (m_drain && !(br && !ms)) begin
                e_pc = 0; e_iffl = 1;
            end
        end
        exp_q.push_back({e_pc, e_sel, e_ifen, e_iffl, e_idexen, e_idexfl, e_exen, e_exfl,
                         e_bub, m_halted, m_err, 16'(m_stalls)});
        if (!do_reset) begin
            if (!m_err && !m_halted && !e_pc && m_stalls < 65535) m_stalls++;
            if (m_err) begin
                m_consec = 0;
            end else if (m_halted) begin
                m_consec = 0;
                if (!hr) m_halted = 0;
            end else begin
                m_consec = ms ? m_consec + 1 : 0;
                if (ms && m_consec == MEM_TIMEOUT) begin
                    m_err = 1; m_drain = 0;
                end else if (m_drain) begin
                    if (!hr) m_drain = 0;
                    else if (!ms) begin
                        m_drained++;
                        if (m_drained == DRAIN_CYCLES) begin
                            m_halted = 1; m_drain = 0;
                        end
                    end
                end else if (!ms && hr) begin
                    m_drain = 1; m_drained = 0;
                end
            end
        end
    endtask

    task automatic idle(input int n, input bit hr);
        for (int i = 0; i < n; i++) drive_cycle(0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 0, 1, hr);
    endtask

    always @(negedge clk) begin
        logic [26:0] e;
        logic [10:0] act_ctrl;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            act_ctrl = {pc_en, pc_sel_branch, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
                        ex_mem_en, ex_mem_flush, mem_wb_bubble, halted, mem_err};
            n_checks++;
            if (act_ctrl !== e[26:16]) begin
                n_fail++;
                $display("FAIL ctrl t=%0t actual=%b required=%b", $time, act_ctrl, e[26:16]);
            end
            n_checks++;
            if (stall_count !== e[15:0]) begin
                n_fail++;
                $display("FAIL stall_count t=%0t actual=%0d required=%0d", $time, stall_count, e[15:0]);
            end
        end
    end

    initial begin
        bit hl;
        int waited;
        model_reset();
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        // load-use on rs, then same with r0 destination
        drive_cycle(0, 5'd8, 5'd1, 5'd8, 0, 1, 0, 0, 1, 0);
        drive_cycle(0, 5'd0, 5'd1, 5'd0, 0, 1, 0, 0, 1, 0);
        drive_cycle(0, 5'd3, 5'd9, 5'd9, 1, 1, 0, 0, 1, 0);
        // branch together with load-use
        drive_cycle(0, 5'd8, 5'd1, 5'd8, 0, 1, 1, 0, 1, 0);
        // three-cycle memory wait, release on the fourth
        for (int i = 0; i < 3; i++) drive_cycle(0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 0);
        drive_cycle(0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 1, 0);
        // 14 stalls stay short of the timeout
        for (int i = 0; i < 14; i++) drive_cycle(0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 0);
        idle(2, 0);
        // 15 stalls reach the timeout; error is sticky until reset
        for (int i = 0; i < 15; i++) drive_cycle(0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 0);
        idle(3, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2, 0);
        // plain halt, hold halted, release
        idle(8, 1);
        idle(2, 0);
        // halt with a stall in the middle of the drain
        idle(2, 1);
        for (int i = 0; i < 3; i++) drive_cycle(0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 1);
        idle(6, 1);
        idle(1, 0);
        // drop halt mid-drain
        idle(2, 1);
        idle(2, 0);
        // branch during drain
        idle(1, 1);
        drive_cycle(0, 5'd8, 5'd1, 5'd8, 0, 1, 1, 0, 1, 1);
        idle(4, 1);
        idle(1, 0);
        // reset mid-wait and mid-drain
        for (int i = 0; i < 5; i++) drive_cycle(0, 5'd1, 5'd2, 5'd3, 0, 0, 0, 1, 0, 0);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        idle(2, 1);
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 1);
        idle(2, 0);
        // randomized traffic
        hl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) < 4) hl = !hl;
            drive_cycle($urandom_range(0, 199) == 0,
                        5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 9) == 0, $urandom_range(0, 99) < 35,
                        1'($urandom_range(0, 1)), hl);
        end
        drive_cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);
        // saturation of the stall counter
        for (int i = 0; i < 70000; i++) drive_cycle(0, 5'd8, 5'd1, 5'd8, 0, 1, 0, 0, 1, 0);
        idle(2, 0);
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queue actual=%0d entries left required=0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush sequencer for the 5-stage pipeline. Combines load-use hazards, branch redirects resolved in MEM, multi-cycle data-memory waits, and external halt requests. Produces per-register enable/flush controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB. Keeps a saturating stall-cycle counter and a sticky memory-timeout error.

## Interface
Parameters:
- MEM_TIMEOUT, 15: max consecutive memory-wait cycles before error (1..255)
- DRAIN_CYCLES, 4: non-stalled cycles spent draining before HALTED (1..7)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- id_rs, id_rt  in  5 each  source registers of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt
- ex_mem_read  in  1  instruction in EX is a load
- ex_rd  in  5  destination register of the instruction in EX
- mem_branch_taken  in  1  taken branch/jump resolved in MEM
- mem_req  in  1  MEM stage is accessing data memory
- mem_ready  in  1  data memory completes the access this cycle
- halt_req  in  1  level request to halt the pipeline
- pc_en, pc_sel_branch  out  1 each  PC load enable; select branch target
- if_id_en, if_id_flush  out  1 each
- id_ex_en, id_ex_flush  out  1 each
- ex_mem_en, ex_mem_flush  out  1 each
- mem_wb_bubble  out  1  MEM/WB loads a bubble
- halted  out  1  pipeline is drained and frozen
- mem_err  out  1  sticky memory timeout
- stall_count  out  16  saturating count of stall cycles

## Operation
- Flush overrides enable at every register: flush loads a bubble (all control fields 0).
- Derived terms, all combinational:
  - load_use = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt))
  - mem_stall = mem_req & ~mem_ready
- Defaults: all `*_en`=1, all flushes=0, pc_sel_branch=0.
- States: RUN, MEM_WAIT, DRAIN, HALTED, ERROR.
- Priority in RUN/MEM_WAIT/DRAIN: mem_stall > mem_branch_taken > load_use.
  - mem_stall: pc/if_id/id_ex/ex_mem en=0; mem_wb_bubble=1; next state MEM_WAIT.
  - Branch: pc_en=1, pc_sel_branch=1; flush if_id, id_ex, ex_mem.
  - load_use: pc_en=0, if_id_en=0, id_ex_flush=1.
- MEM_WAIT: wait_cnt increments each mem_stall cycle.
  - mem_stall=0 → release that cycle using RUN rules; return to RUN, or to DRAIN if halt_req.
  - wait_cnt reaches MEM_TIMEOUT → ERROR.
- halt_req=1 in RUN → DRAIN with drain_cnt=0.
  - DRAIN forces pc_en=0 and if_id_flush=1, except a branch loads the PC and still flushes.
  - drain_cnt increments on non-mem_stall cycles. At DRAIN_CYCLES → HALTED.
  - halt_req=0 during DRAIN → RUN next cycle.
- HALTED: all en=0, halted=1. halt_req=0 → RUN next cycle.
- ERROR: all en=0, mem_err=1. Only reset exits.
- stall_count increments in any cycle with pc_en=0 while not HALTED/ERROR. Saturates at 0xFFFF.

## Timing
- Enables/flushes are combinational from state and inputs in the same cycle. State, wait_cnt, drain_cnt, stall_count and mem_err are registered.
- Reset (rst_n=0, immediate): state=RUN, counters=0, mem_err=0, halted=0. Outputs then follow RUN rules.
- Reset mid-wait or mid-drain discards the operation; no error is raised.
- Load-use costs exactly 1 bubble. Branch costs 3 flushed slots. Timeout is declared on the edge where the MEM_TIMEOUT-th consecutive stall cycle completes.

## Structure
- Package pipe_ctrl_pkg holds:
  - state enum (3 bits)
  - REG_ADDR_W=5
  - STALL_CNT_W=16
- Sub-module load_use_detect holds the combinational register-compare logic; the FSM and counters stay at top level.

## Test plan
- EX=lw ex_rd=8, ID id_rs=8 → one cycle pc_en=0, id_ex_flush=1; stall_count=1. With ex_rd=0 → no stall.
- mem_branch_taken=1 together with load_use=1 → pc_sel_branch=1, three flushes, no id_ex_en hold.
- mem_req=1, mem_ready low for 3 cycles → all front enables 0 for 3 cycles, mem_wb_bubble=1; release on cycle 4; stall_count=3.
- mem_ready held low 15 cycles (MEM_TIMEOUT=15) → ERROR, mem_err=1 sticky; rst_n pulse clears it.
- halt_req=1 → 4 flushed cycles, then halted=1. Drop halt_req → RUN next cycle. A mem_stall inside DRAIN extends the drain by the stall length.
- 70000 consecutive load-use stimuli → stall_count saturates at 0xFFFF.
